// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit preamble layout and the injection framing states.
package noc;

    // Sits at the MSBs of every flit: [Width-1]=head, [Width-2]=tail.
    typedef struct packed {
        logic head;
        logic tail;
    } preamble_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } inject_state_t;

endpackage

// File: rtl/noc_inject_fifo.sv
// Flop-based FIFO with wrap-bit counters.
// The head entry is read straight out of the storage flops.
module noc_inject_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [Width-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [Width-1:0]           rd_data,
    output logic [$clog2(Depth):0]     count
);
    localparam int AW = $clog2(Depth);

    logic [AW:0]      wr_cnt;
    logic [AW:0]      rd_cnt;
    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_en) wr_cnt <= wr_cnt + (AW+1)'(1);
            if (rd_en) rd_cnt <= rd_cnt + (AW+1)'(1);
        end
    end

    // Storage is not reset; the counters alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_cnt[AW-1:0]];
    assign count   = wr_cnt - rd_cnt;

endmodule

// File: rtl/noc_local_inject_queue.sv
// Tile-to-router injection queue with packet framing checks.
// Define NOC_INJECT_SAF_EN for store-and-forward presentation of packets.
//
// state | meaning
// IDLE  | between packets, next accepted flit must be a head
// BODY  | head accepted, waiting for body/tail flits
module noc_local_inject_queue #(
    parameter int Width       = 32,
    parameter int Depth       = 4,
    parameter int MaxPktFlits = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Width-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [Width-1:0]           data_p_out,
    output logic                       data_void_out,
    input  logic                       stop_in,
    output logic [$clog2(Depth):0]     occupancy,
    output logic                       frame_err
);
    import noc::*;

    localparam int CW  = $clog2(Depth) + 1;
    localparam int FCW = $clog2(MaxPktFlits + 1);

    logic             enq;
    logic             deq;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [Width-1:0] head_data;
    logic             empty_q;
    preamble_t        in_pre;

    inject_state_t    state;
    logic [FCW-1:0]   flit_cnt;

    assign in_pre    = preamble_t'(in_data[Width-1 -: 2]);
    assign enq       = in_valid & in_ready;
    assign deq       = ~data_void_out & ~stop_in;
    assign count_nxt = count + CW'(enq) - CW'(deq);

    noc_inject_fifo #(
        .Width (Width),
        .Depth (Depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (enq),
        .wr_data (in_data),
        .rd_en   (deq),
        .rd_data (head_data),
        .count   (count)
    );

    assign data_p_out = head_data;
    assign occupancy  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            in_ready <= (count_nxt != CW'(Depth));
            empty_q  <= (count_nxt == '0);
        end
    end

`ifdef NOC_INJECT_SAF_EN
    logic [CW-1:0] complete_pkts;

    always_ff @(posedge clk) begin
        if (rst) begin
            complete_pkts <= '0;
        end else begin
            complete_pkts <= complete_pkts + CW'(enq & in_pre.tail)
                                           - CW'(deq & head_data[Width-2]);
        end
    end

    // A head waits until its whole packet is stored; only registered terms,
    // so the output cannot change while the router holds stop.
    assign data_void_out = empty_q | (head_data[Width-1] & (complete_pkts == '0));
`else
    assign data_void_out = empty_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flit_cnt  <= '0;
            frame_err <= 1'b0;
        end else if (enq) begin
            case (state)
                IDLE: begin
                    if (!in_pre.head) begin
                        frame_err <= 1'b1;
                    end else if (!in_pre.tail) begin
                        state    <= BODY;
                        flit_cnt <= FCW'(1);
                    end
                end
                BODY: begin
                    if (in_pre.head) begin
                        // Unexpected head restarts the packet.
                        frame_err <= 1'b1;
                        if (in_pre.tail) state <= IDLE;
                        else             flit_cnt <= FCW'(1);
                    end else if (in_pre.tail) begin
                        state <= IDLE;
                    end else if (flit_cnt == FCW'(MaxPktFlits - 1)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        flit_cnt <= flit_cnt + FCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_local_inject_queue.sv
// Directed self-checking bench for noc_local_inject_queue (Depth=4).
module tb_noc_local_inject_queue;

`ifdef NOC_INJECT_SAF_EN
    localparam int MAX_PKT = 4;
`else
    localparam int MAX_PKT = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_p_out;
    logic        data_void_out;
    logic        stop_in;
    logic [2:0]  occupancy;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    noc_local_inject_queue #(
        .Width       (32),
        .Depth       (4),
        .MaxPktFlits (MAX_PKT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_p_out    (data_p_out),
        .data_void_out (data_void_out),
        .stop_in       (stop_in),
        .occupancy     (occupancy),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [1:0] pre, input int val);
        return {pre, 30'(val)};
    endfunction

    // Hold a flit until it is accepted, then drop in_valid.
    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50 && !in_ready; t++) tick();
        if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        stop_in  = 1'b0;

        // reset
        tick();
        chk("rst_rdy", 32'(in_ready), 32'd0);
        tick();
        chk("rst_void", 32'(data_void_out), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_rdy", 32'(in_ready), 32'd1);
        chk("rel_void", 32'(data_void_out), 32'd1);

        // single-flit stream, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = mk(2'b11, 100 + i);
            tick();
            chk("str_data", data_p_out, mk(2'b11, 100 + i));
            chk("str_void", 32'(data_void_out), 32'd0);
            chk("str_occ", 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("str_end_void", 32'(data_void_out), 32'd1);
        chk("str_end_occ", 32'(occupancy), 32'd0);

        // backpressure: fill 4, fifth waits
        stop_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rdy", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = mk(2'b11, 200 + i);
            tick();
        end
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        chk("bp_full_occ", 32'(occupancy), 32'd4);
        in_data = mk(2'b11, 204);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_hold_data", data_p_out, mk(2'b11, 200));
            chk("bp_hold_void", 32'(data_void_out), 32'd0);
            chk("bp_hold_occ", 32'(occupancy), 32'd4);
        end
        stop_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_data", data_p_out, mk(2'b11, 200 + k));
            chk("bp_drain_void", 32'(data_void_out), 32'd0);
            acc = in_valid & in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        chk("bp_done_void", 32'(data_void_out), 32'd1);
        chk("bp_done_occ", 32'(occupancy), 32'd0);

        // reset in the middle of a packet
        stop_in = 1'b1;
        push(mk(2'b10, 300));
        push(mk(2'b00, 301));
        push(mk(2'b00, 302));
        chk("mid_occ", 32'(occupancy), 32'd3);
        chk("mid_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_void", 32'(data_void_out), 32'd1);
        rst     = 1'b0;
        stop_in = 1'b0;
        // a head in BODY would flag an error, so this proves IDLE
        push(mk(2'b11, 310));
        chk("mid_idle_err", 32'(frame_err), 32'd0);
        chk("mid_idle_data", data_p_out, mk(2'b11, 310));
        tick();
        chk("mid_idle_void", 32'(data_void_out), 32'd1);

        // orphan body flit in IDLE
        push(mk(2'b00, 320));
        chk("orphan_err", 32'(frame_err), 32'd1);
        tick();

`ifndef NOC_INJECT_SAF_EN
        // longest legal packet, then one flit too long
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("len_rst_err", 32'(frame_err), 32'd0);
        push(mk(2'b10, 400));
        for (int i = 1; i < 15; i++) push(mk(2'b00, 400 + i));
        push(mk(2'b01, 415));
        chk("len16_err", 32'(frame_err), 32'd0);
        push(mk(2'b10, 500));
        for (int i = 1; i < 15; i++) push(mk(2'b00, 500 + i));
        chk("len15_err", 32'(frame_err), 32'd0);
        push(mk(2'b00, 515));
        chk("len17_err", 32'(frame_err), 32'd1);
        push(mk(2'b01, 516));
        chk("len17_sticky", 32'(frame_err), 32'd1);
        tick();
        chk("len_void", 32'(data_void_out), 32'd1);
`else
        // store-and-forward: head held until tail is stored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push(mk(2'b10, 600));
        chk("saf_h_void", 32'(data_void_out), 32'd1);
        tick();
        tick();
        chk("saf_h_wait", 32'(data_void_out), 32'd1);
        push(mk(2'b00, 601));
        chk("saf_b_void", 32'(data_void_out), 32'd1);
        tick();
        tick();
        chk("saf_b_occ", 32'(occupancy), 32'd2);
        push(mk(2'b01, 602));
        chk("saf_t_void", 32'(data_void_out), 32'd0);
        chk("saf_f0", data_p_out, mk(2'b10, 600));
        tick();
        chk("saf_f1", data_p_out, mk(2'b00, 601));
        chk("saf_f1_void", 32'(data_void_out), 32'd0);
        tick();
        chk("saf_f2", data_p_out, mk(2'b01, 602));
        chk("saf_f2_void", 32'(data_void_out), 32'd0);
        tick();
        chk("saf_end_void", 32'(data_void_out), 32'd1);
        chk("saf_err", 32'(frame_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
